// File: rtl/tap_uart_pkg.sv
// Shared types for the UART -> TAP/DMI command path: op codes, assembler
// states and the frame layout handed to the TAP/DMI logic.
package tap_uart_pkg;

    localparam int OP_W           = 2;
    localparam int ADDR_W         = 6;
    localparam int MAX_DATA_BYTES = 8;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        EMIT
    } asm_state_e;

    // Widest possible frame; narrower builds use the low 8*DATA_BYTES bits.
    typedef struct packed {
        op_e                             op;
        logic [ADDR_W-1:0]               addr;
        logic [8*MAX_DATA_BYTES-1:0]     data;
    } frame_t;

endpackage

// File: rtl/rx_watchdog.sv
// Idle watchdog for a partially collected frame: counts consecutive active
// cycles and raises expire on the TIMEOUT_CYCLES-th one. Dropping active
// (a pop, or leaving COLLECT) clears the count.
module rx_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // Count idle cycles, restart whenever the idle run is broken, hold at the limit.
    always_ff @(posedge clk) begin
        if (rst || !active) begin
            cnt_q <= '0;
        end else if (cnt_q != LAST_CNT) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expire = active && (cnt_q == LAST_CNT);

endmodule

// File: rtl/tap_rx_assembler.sv
// Assembles unescaped bytes/command flags from the UART escape filter into
// (op, addr, data) frames for the TAP/DMI logic. Any command byte resyncs;
// stray data and reserved commands are dropped.
// Optional: define TAP_RX_TIMEOUT_EN to abort partial WRITE frames after
// TIMEOUT_CYCLES idle cycles (instantiates rx_watchdog).
module tap_rx_assembler
    import tap_uart_pkg::*;
#(
    parameter int unsigned DATA_BYTES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                    CLK_I,
    input  logic                    RST_I,
    input  logic                    RX_EMPTY_I,
    input  logic                    CMD_REC_I,
    input  logic [7:0]              DATA_REC_I,
    output logic                    READ_O,
    output logic                    FRAME_VALID_O,
    input  logic                    FRAME_READY_I,
    output logic [OP_W-1:0]         FRAME_OP_O,
    output logic [ADDR_W-1:0]       FRAME_ADDR_O,
    output logic [8*DATA_BYTES-1:0] FRAME_DATA_O,
    output logic                    ABORT_O,
    output logic                    DROP_O
);

    localparam int CNT_W = $clog2(DATA_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_BYTES - 1);

    asm_state_e              state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    op_e                     op_q, op_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [8*DATA_BYTES-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    abort_q, abort_d;
    logic                    drop_q, drop_d;

    logic                    pop;
    op_e                     cmd_op;
    logic                    wd_expire;

    // A byte is consumed whenever one is offered, except while a frame waits for the consumer.
    assign pop    = !RX_EMPTY_I && !RST_I && (state_q != EMIT);
    assign cmd_op = op_e'(DATA_REC_I[7:6]);

`ifdef TAP_RX_TIMEOUT_EN
    logic wd_active;

    assign wd_active = (state_q == COLLECT) && RX_EMPTY_I;

    rx_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx_watchdog (
        .clk   (CLK_I),
        .rst   (RST_I),
        .active(wd_active),
        .expire(wd_expire)
    );
`else
    // No watchdog: a partial frame waits indefinitely.
    assign wd_expire = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    // Next-state and next-frame decode; the frame registers only change on a pop or a timeout.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        abort_d = 1'b0;
        drop_d  = 1'b0;

        if (state_q == EMIT) begin
            if (FRAME_READY_I) begin
                state_d = IDLE;
            end
        end else if (wd_expire) begin
            abort_d = 1'b1;
            state_d = IDLE;
            count_d = '0;
        end else if (pop) begin
            if (CMD_REC_I) begin
                // A command in the middle of a WRITE throws the partial frame away.
                if (state_q == COLLECT) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end
                count_d = '0;
                case (cmd_op)
                    OP_READ: begin
                        op_d    = OP_READ;
                        addr_d  = DATA_REC_I[ADDR_W-1:0];
                        data_d  = '0;
                        state_d = EMIT;
                    end
                    OP_WRITE: begin
                        op_d    = OP_WRITE;
                        addr_d  = DATA_REC_I[ADDR_W-1:0];
                        data_d  = '0;
                        state_d = COLLECT;
                    end
                    OP_RSVD: begin
                        drop_d  = 1'b1;
                        state_d = IDLE;
                    end
                    default: begin
                    end
                endcase
            end else if (state_q == COLLECT) begin
                data_d[8*count_q +: 8] = DATA_REC_I;
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST_CNT) begin
                    state_d = EMIT;
                end
            end else begin
                drop_d = 1'b1;
            end
        end

        valid_d = (state_d == EMIT);
    end

    // State, frame and pulse registers; reset clears everything without an abort pulse.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= IDLE;
            count_q <= '0;
            op_q    <= OP_NOP;
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            abort_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            abort_q <= abort_d;
            drop_q  <= drop_d;
        end
    end

    assign READ_O        = pop;
    assign FRAME_VALID_O = valid_q;
    assign FRAME_OP_O    = op_q;
    assign FRAME_ADDR_O  = addr_q;
    assign FRAME_DATA_O  = data_q;
    assign ABORT_O       = abort_q;
    assign DROP_O        = drop_q;

endmodule

// File: tb/tb_tap_rx_assembler.sv
// Directed bench for tap_rx_assembler (DATA_BYTES=4). Inputs change on the
// falling edge; outputs are sampled on the falling edge. The timeout case is
// exercised only when TAP_RX_TIMEOUT_EN is defined.
module tb_tap_rx_assembler;

    logic        clk;
    logic        rst;
    logic        rx_empty;
    logic        cmd_rec;
    logic [7:0]  data_rec;
    logic        read_o;
    logic        frame_valid;
    logic        frame_ready;
    logic [1:0]  frame_op;
    logic [5:0]  frame_addr;
    logic [31:0] frame_data;
    logic        abort_o;
    logic        drop_o;

    int checks   = 0;
    int failures = 0;

    tap_rx_assembler #(
        .DATA_BYTES    (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .CLK_I        (clk),
        .RST_I        (rst),
        .RX_EMPTY_I   (rx_empty),
        .CMD_REC_I    (cmd_rec),
        .DATA_REC_I   (data_rec),
        .READ_O       (read_o),
        .FRAME_VALID_O(frame_valid),
        .FRAME_READY_I(frame_ready),
        .FRAME_OP_O   (frame_op),
        .FRAME_ADDR_O (frame_addr),
        .FRAME_DATA_O (frame_data),
        .ABORT_O      (abort_o),
        .DROP_O       (drop_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offer one byte for a single cycle; it must be popped at the next rising edge.
    task automatic push(input logic is_cmd, input logic [7:0] b);
        rx_empty = 1'b0;
        cmd_rec  = is_cmd;
        data_rec = b;
        #1;
        check("read_on_push", read_o, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rx_empty = 1'b1;
        cmd_rec  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        rx_empty    = 1'b1;
        cmd_rec     = 1'b0;
        data_rec    = 8'h00;
        frame_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", frame_valid, 1'b0);
        check("rst_op",    frame_op,    2'b00);
        check("rst_addr",  frame_addr,  6'h00);
        check("rst_data",  frame_data,  32'h0);
        check("rst_abort", abort_o,     1'b0);
        check("rst_drop",  drop_o,      1'b0);
        check("rst_read",  read_o,      1'b0);
        rst = 1'b0;
        step();

        // 1: WRITE 0x85 with four bytes, consumer ready
        push(1'b1, 8'h85);
        check("t1_collect_novalid", frame_valid, 1'b0);
        push(1'b0, 8'h11);
        push(1'b0, 8'h22);
        push(1'b0, 8'h33);
        push(1'b0, 8'h44);
        check("t1_valid", frame_valid, 1'b1);
        check("t1_op",    frame_op,    2'b10);
        check("t1_addr",  frame_addr,  6'h05);
        check("t1_data",  frame_data,  32'h44332211);
        step();
        check("t1_valid_one_cycle", frame_valid, 1'b0);

        // 2: READ 0x4A held under backpressure with a byte waiting
        frame_ready = 1'b0;
        push(1'b1, 8'h4A);
        rx_empty = 1'b0;
        cmd_rec  = 1'b0;
        data_rec = 8'h99;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t2_valid_held", frame_valid, 1'b1);
            check("t2_addr",       frame_addr,  6'h0A);
            check("t2_op",         frame_op,    2'b01);
            check("t2_data",       frame_data,  32'h0);
            check("t2_no_pop",     read_o,      1'b0);
            step();
        end
        rx_empty    = 1'b1;
        frame_ready = 1'b1;
        step();
        check("t2_valid_after_hs", frame_valid, 1'b0);
        rx_empty = 1'b0;
        #1;
        check("t2_pop_resumes", read_o, 1'b1);
        rx_empty = 1'b1;

        // 3: WRITE 0x81 interrupted by READ 0x42
        frame_ready = 1'b0;
        push(1'b1, 8'h81);
        push(1'b0, 8'hAA);
        push(1'b0, 8'hBB);
        push(1'b1, 8'h42);
        check("t3_abort", abort_o,     1'b1);
        check("t3_valid", frame_valid, 1'b1);
        check("t3_op",    frame_op,    2'b01);
        check("t3_addr",  frame_addr,  6'h02);
        check("t3_data",  frame_data,  32'h0);
        frame_ready = 1'b1;
        step();
        check("t3_abort_pulse", abort_o,     1'b0);
        check("t3_hs_done",     frame_valid, 1'b0);

        // 4: stray data then reserved command
        push(1'b0, 8'h55);
        check("t4_drop_data",  drop_o,      1'b1);
        check("t4_no_frame_a", frame_valid, 1'b0);
        push(1'b1, 8'hC0);
        check("t4_drop_rsvd",  drop_o,      1'b1);
        check("t4_no_frame_b", frame_valid, 1'b0);
        step();
        check("t4_drop_pulse", drop_o,      1'b0);
        push(1'b1, 8'h41);
        check("t4_idle_read",  frame_valid, 1'b1);
        check("t4_idle_addr",  frame_addr,  6'h01);
        step();

        // 5: reset in the middle of a WRITE
        push(1'b1, 8'h85);
        push(1'b0, 8'h01);
        push(1'b0, 8'h02);
        rst      = 1'b1;
        rx_empty = 1'b0;
        data_rec = 8'h03;
        step();
        check("t5_read_in_rst", read_o,      1'b0);
        check("t5_valid",       frame_valid, 1'b0);
        check("t5_op",          frame_op,    2'b00);
        check("t5_addr",        frame_addr,  6'h00);
        check("t5_data",        frame_data,  32'h0);
        check("t5_abort",       abort_o,     1'b0);
        check("t5_drop",        drop_o,      1'b0);
        rst      = 1'b0;
        rx_empty = 1'b1;
        step();
        push(1'b1, 8'h9F);
        push(1'b0, 8'hA1);
        push(1'b0, 8'hB2);
        push(1'b0, 8'hC3);
        push(1'b0, 8'hD4);
        check("t5_valid_after", frame_valid, 1'b1);
        check("t5_op_after",    frame_op,    2'b10);
        check("t5_addr_after",  frame_addr,  6'h1F);
        check("t5_data_after",  frame_data,  32'hD4C3B2A1);
        step();

`ifdef TAP_RX_TIMEOUT_EN
        // 6: partial WRITE abandoned for 16 idle cycles
        push(1'b1, 8'h83);
        push(1'b0, 8'h77);
        for (int i = 0; i < 15; i++) begin
            step();
            check("t6_no_early_abort", abort_o, 1'b0);
        end
        step();
        check("t6_abort",       abort_o,     1'b1);
        check("t6_no_frame",    frame_valid, 1'b0);
        push(1'b0, 8'h12);
        check("t6_drop_after",  drop_o,      1'b1);
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
